// File: rtl/register_file_bwc.sv
// Register file: N words x W bits, one byte-enabled write port, two read ports,
// optional write-to-read bypass, optional registered reads, and a one-word-per-cycle clear engine.
module register_file_bwc #(
    parameter int unsigned M       = 4,
    parameter int unsigned N       = 16,
    parameter int unsigned W       = 8,
    parameter bit          BYPASS  = 1'b1,
    parameter bit          REG_OUT = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_enable,
    input  logic [W/8-1:0] wr_be,
    input  logic [M-1:0]   wr_addr,
    input  logic [W-1:0]   din,
    input  logic [M-1:0]   rd_addra,
    input  logic [M-1:0]   rd_addrb,
    input  logic           clr_req,
    output logic [W-1:0]   douta,
    output logic [W-1:0]   doutb,
    output logic           busy
);

    localparam int unsigned NB      = W / 8;
    localparam logic [M-1:0] LastPtr = M'(N - 1);

    typedef enum logic {StIdle, StClear} state_e;

    state_e         state_q, state_d;
    logic [M-1:0]   ptr_q, ptr_d;
    logic [W-1:0]   mem [N];
    logic [W-1:0]   merged;
    logic [W-1:0]   rd_a, rd_b;
    logic           wr_fire, clr_fire;
    logic           wr_in_range, rda_in_range, rdb_in_range;

    assign busy         = (state_q == StClear);
    assign wr_in_range  = (32'(wr_addr) < N);
    assign rda_in_range = (32'(rd_addra) < N);
    assign rdb_in_range = (32'(rd_addrb) < N);

    // A write accepted in the same cycle as clr_req is dropped: clear wins.
    assign wr_fire  = !rst && (state_q == StIdle) && !clr_req && wr_enable && wr_in_range;
    assign clr_fire = !rst && (state_q == StClear);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (clr_req) begin
                    state_d = StClear;
                    ptr_d   = '0;
                end
            end
            StClear: begin
                if (ptr_q == LastPtr) begin
                    state_d = StIdle;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: begin
                state_d = StClear;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StClear;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        merged = mem[wr_addr];
        for (int i = 0; i < NB; i++) begin
            if (wr_be[i]) merged[8*i +: 8] = din[8*i +: 8];
        end
    end

    // Array has no reset; the clear sweep is what zeroes it.
    always_ff @(posedge clk) begin
        if (clr_fire) begin
            mem[ptr_q] <= '0;
        end else if (wr_fire) begin
            mem[wr_addr] <= merged;
        end
    end

    always_comb begin
        rd_a = '0;
        rd_b = '0;
        if (!busy && rda_in_range) begin
            if (BYPASS && wr_fire && (wr_addr == rd_addra)) rd_a = merged;
            else                                             rd_a = mem[rd_addra];
        end
        if (!busy && rdb_in_range) begin
            if (BYPASS && wr_fire && (wr_addr == rd_addrb)) rd_b = merged;
            else                                             rd_b = mem[rd_addrb];
        end
    end

    if (REG_OUT) begin : g_reg_out
        logic [W-1:0] douta_q, doutb_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                douta_q <= '0;
                doutb_q <= '0;
            end else begin
                douta_q <= rd_a;
                doutb_q <= rd_b;
            end
        end
        assign douta = douta_q;
        assign doutb = doutb_q;
    end else begin : g_comb_out
        assign douta = rd_a;
        assign doutb = rd_b;
    end

endmodule
